// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin decision: a lone requester wins, a tie goes to the one not served last.
module rr_pick2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last_b,
  output logic gnt_valid,
  output logic gnt_b
);

  always_comb begin
    gnt_valid = req_a | req_b;
    gnt_b     = req_b & (~req_a | ~last_b);
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates ports A and B onto a single-ported data memory; one access per three cycles.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_stall,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_stall,
  output logic [DATA_W-1:0] rdata,
  output logic              misalign,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state;
  logic              last_b;
  logic              sel_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              gnt_valid;
  logic              gnt_b;
  logic              pick_we;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] pick_wdata;

  rr_pick2 u_rr_pick2 (
    .req_a     (a_req),
    .req_b     (b_req),
    .last_b    (last_b),
    .gnt_valid (gnt_valid),
    .gnt_b     (gnt_b)
  );

  always_comb begin
    pick_we    = gnt_b ? b_we    : a_we;
    pick_addr  = gnt_b ? b_addr  : a_addr;
    pick_wdata = gnt_b ? b_wdata : a_wdata;
  end

  assign a_stall = a_req & ~a_ack;
  assign b_stall = b_req & ~b_ack;
  assign busy    = state != IDLE;

  // Memory strobes are set on entry to ISSUE so they are high for exactly that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_b    <= 1'b1;
      sel_q     <= SEL_A;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      misalign  <= 1'b0;
      rdata     <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      misalign  <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_valid) begin
            sel_q     <= gnt_b;
            we_q      <= pick_we;
            addr_q    <= pick_addr;
            wdata_q   <= pick_wdata;
            mem_read  <= ~pick_we;
            mem_write <= pick_we;
            mem_addr  <= pick_addr;
            mem_wdata <= pick_wdata;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!we_q) rdata <= mem_rdata;
          a_ack    <= sel_q == SEL_A;
          b_ack    <= sel_q == SEL_B;
          misalign <= is_misaligned(addr_q[1:0]);
          state    <= DONE;
        end
        DONE: begin
          last_b <= sel_q;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter with a negedge-sampling memory model.
module tb_dmem_port_arbiter;

  typedef struct {
    bit          port_b;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_mis;
  } vec_t;

  typedef struct {
    bit          port_b;
    bit          we;
    logic [31:0] rdata;
    bit          mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
  logic        a_ack, a_stall, b_ack, b_stall, misalign, busy, mem_read, mem_write;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem [0:63];
  bit          load_en = 1'b1;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  exp_t        sb[$];
  logic [31:0] last_rd = '0;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_ack     (a_ack),
    .a_stall   (a_stall),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_ack     (b_ack),
    .b_stall   (b_stall),
    .rdata     (rdata),
    .misalign  (misalign),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Memory acts on the falling edge, as the real data memory does.
  always @(negedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 64; i++) mem[i] <= (i < 4) ? 32'(i + 1) : 32'h0;
    end else begin
      if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
      if (mem_read) mem_rdata <= mem[mem_addr[7:2]];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every ack pops the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) last_rd = '0;
    if (mem_read && mem_write) check("strobes_exclusive", 1, 0);
    if (a_ack || b_ack) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", {a_ack, b_ack}, 0);
      end else begin
        e = sb.pop_front();
        check("ack_port", {a_ack, b_ack}, e.port_b ? 2'b01 : 2'b10);
        check("ack_misalign", misalign, e.mis);
        check("ack_rdata", rdata, e.we ? last_rd : e.rdata);
        if (!e.we) last_rd = e.rdata;
      end
    end
  end

  task automatic push_exp(input bit port_b, input bit we, input logic [31:0] rd, input bit mis);
    exp_t e;
    e.port_b = port_b;
    e.we     = we;
    e.rdata  = rd;
    e.mis    = mis;
    sb.push_back(e);
  endtask

  task automatic set_port(input bit port_b, input bit req, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    if (port_b) begin
      b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
    end
  endtask

  // Single access from one port: checks ack latency, stall and the ISSUE-cycle strobes.
  task automatic run_one(input vec_t v);
    logic ack, stall;
    push_exp(v.port_b, v.we, v.exp_rdata, v.exp_mis);
    set_port(v.port_b, 1'b1, v.we, v.addr, v.wdata);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      ack   = v.port_b ? b_ack : a_ack;
      stall = v.port_b ? b_stall : a_stall;
      check("ack_latency", ack, k == 3);
      check("stall", stall, k != 3);
      check("mem_write", mem_write, (k == 2) && v.we);
      check("mem_read", mem_read, (k == 2) && !v.we);
      if (k == 2) check("mem_addr", mem_addr, v.addr);
      if (k == 2 && v.we) check("mem_wdata", mem_wdata, v.wdata);
    end
    @(posedge clk);
    #1;
    set_port(v.port_b, 1'b0, 1'b0, '0, '0);
  endtask

  vec_t tbl[8];

  initial begin
    int n_acks;
    int ack_cyc[4];

    tbl[0] = '{port_b: 0, we: 1, addr: 32'h10, wdata: 32'hDEADBEEF, exp_rdata: 0, exp_mis: 0};
    tbl[1] = '{port_b: 0, we: 0, addr: 32'h10, wdata: 0, exp_rdata: 32'hDEADBEEF, exp_mis: 0};
    tbl[2] = '{port_b: 1, we: 0, addr: 32'h0, wdata: 0, exp_rdata: 32'd1, exp_mis: 0};
    tbl[3] = '{port_b: 1, we: 0, addr: 32'h4, wdata: 0, exp_rdata: 32'd2, exp_mis: 0};
    tbl[4] = '{port_b: 1, we: 0, addr: 32'h8, wdata: 0, exp_rdata: 32'd3, exp_mis: 0};
    tbl[5] = '{port_b: 1, we: 0, addr: 32'hC, wdata: 0, exp_rdata: 32'd4, exp_mis: 0};
    tbl[6] = '{port_b: 1, we: 1, addr: 32'h22, wdata: 32'hCAFEF00D, exp_rdata: 0, exp_mis: 1};
    tbl[7] = '{port_b: 1, we: 0, addr: 32'h20, wdata: 0, exp_rdata: 32'hCAFEF00D, exp_mis: 0};

    // Reset, then idle with no requests.
    repeat (2) @(posedge clk);
    #1;
    load_en = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_flags", {a_ack, b_ack, misalign, busy, mem_read, mem_write, a_stall, b_stall}, 0);
      check("idle_mem_addr", mem_addr, 0);
      check("idle_mem_wdata", mem_wdata, 0);
      check("idle_rdata", rdata, 0);
    end
    @(posedge clk);
    #1;

    // Single-port accesses, back to back.
    for (int i = 0; i < 8; i++) run_one(tbl[i]);
    check("mem_word8", mem[8], 32'hCAFEF00D);

    // Both ports held: grants alternate starting with A.
    push_exp(0, 0, 32'hDEADBEEF, 0);
    push_exp(1, 0, 32'd1, 0);
    push_exp(0, 0, 32'hDEADBEEF, 0);
    push_exp(1, 0, 32'd1, 0);
    set_port(0, 1'b1, 1'b0, 32'h10, '0);
    set_port(1, 1'b1, 1'b0, 32'h0, '0);
    n_acks = 0;
    for (int c = 0; c < 40 && n_acks < 4; c++) begin
      @(negedge clk);
      if (a_ack || b_ack) begin
        ack_cyc[n_acks] = cyc;
        n_acks++;
      end
    end
    check("tie_ack_count", n_acks, 4);
    for (int i = 1; i < 4; i++) check("tie_ack_spacing", ack_cyc[i] - ack_cyc[i-1], 3);
    @(posedge clk);
    #1;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);

    // Misaligned read leaves A as the last served port.
    run_one('{port_b: 0, we: 0, addr: 32'h23, wdata: 0, exp_rdata: 32'hCAFEF00D, exp_mis: 1});

    // Reset during ISSUE of an A write: the write lands, no ack follows.
    set_port(0, 1'b1, 1'b1, 32'h40, 32'h55);
    @(negedge clk);
    @(negedge clk);
    check("rst_issue_write", mem_write, 1);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    set_port(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("rst_no_ack", {a_ack, busy}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_word16", mem[16], 32'h55);

    // Tie after reset goes to A again.
    push_exp(0, 0, 32'h55, 0);
    push_exp(1, 0, 32'd2, 0);
    set_port(0, 1'b1, 1'b0, 32'h40, '0);
    set_port(1, 1'b1, 1'b0, 32'h4, '0);
    n_acks = 0;
    for (int c = 0; c < 20 && n_acks < 2; c++) begin
      @(negedge clk);
      if (a_ack || b_ack) n_acks++;
    end
    check("post_rst_ack_count", n_acks, 2);
    @(posedge clk);
    #1;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);

    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
